// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Front end of the instruction path, sitting directly in front of a
//   2**ADDR_WIDTH x DATA_WIDTH instruction memory with a combinational read port.
//   - LOAD: boot words are accepted over a valid/ready handshake and written
//     sequentially from word address 0.
//   - RUN: the unit owns the program counter, drives the memory read address
//     and captures the returned word into the IF/ID register.
//   - Supports stall, redirect (branch/jump) and halt.
//
// Ports
//   clk, rst_all                 clock, synchronous active-high reset
//   boot_start                   begin a boot load (honoured in IDLE or HALT only)
//   load_valid/load_data/load_last/load_ready   boot word stream handshake
//   imem_we/imem_write_addr/imem_write_data      memory write port
//   imem_read_addr/imem_read_data                memory read port (combinational)
//   stall, redirect, redirect_addr, halt_req     run-phase control
//   if_instr, if_pc, if_valid                    IF/ID register to decode
//   state                        IDLE=0, LOAD=1, RUN=2, HALT=3
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_all,
  input  logic                  boot_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_write_addr,
  output logic [DATA_WIDTH-1:0] imem_write_data,
  output logic [ADDR_WIDTH-1:0] imem_read_addr,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  halt_req,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_valid,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] load_cnt_reg;
  logic [DATA_WIDTH-1:0] if_instr_reg;
  logic [ADDR_WIDTH-1:0] if_pc_reg;
  logic                  if_valid_reg;

  // Memory-side signals are combinational so a boot word is written on the
  // same edge it is accepted, and the fetched word is ready within the cycle.
  assign load_ready      = (state_reg == ST_LOAD);
  assign imem_we         = (state_reg == ST_LOAD) && load_valid;
  assign imem_write_addr = load_cnt_reg;
  assign imem_write_data = load_data;
  assign imem_read_addr  = pc_reg;

  assign if_instr = if_instr_reg;
  assign if_pc    = if_pc_reg;
  assign if_valid = if_valid_reg;
  assign state    = state_reg;

  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC;
      load_cnt_reg <= '0;
      if_instr_reg <= '0;
      if_pc_reg    <= '0;
      if_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if_valid_reg <= 1'b0;
          if (boot_start) begin
            state_reg    <= ST_LOAD;
            load_cnt_reg <= '0;
          end
        end

        ST_LOAD: begin
          if_valid_reg <= 1'b0;
          if (load_valid) begin
            // The last word is either flagged explicitly or implied by
            // filling the final memory location.
            if (load_last || (load_cnt_reg == LAST_ADDR)) begin
              state_reg    <= ST_RUN;
              pc_reg       <= RESET_PC;
              load_cnt_reg <= '0;
            end else begin
              load_cnt_reg <= load_cnt_reg + ADDR_ONE;
            end
          end
        end

        ST_RUN: begin
          if (halt_req) begin
            state_reg    <= ST_HALT;
            if_valid_reg <= 1'b0;
          end else if (redirect) begin
            // The word at the old pc is wrong-path: drop it, keep the
            // stale IF/ID contents but mark them dead.
            pc_reg       <= redirect_addr;
            if_valid_reg <= 1'b0;
          end else if (!stall) begin
            if_instr_reg <= imem_read_data;
            if_pc_reg    <= pc_reg;
            if_valid_reg <= 1'b1;
            pc_reg       <= pc_reg + ADDR_ONE;  // wraps modulo depth
          end
        end

        ST_HALT: begin
          if_valid_reg <= 1'b0;
          if (boot_start) begin
            state_reg    <= ST_LOAD;
            load_cnt_reg <= '0;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_all, boot_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready, imem_we;
  logic [6:0]  imem_write_addr, imem_read_addr;
  logic [31:0] imem_write_data, imem_read_data;
  logic        stall, redirect, halt_req;
  logic [6:0]  redirect_addr;
  logic [31:0] if_instr;
  logic [6:0]  if_pc;
  logic        if_valid;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  // 128x32 instruction memory model, combinational read.
  logic [31:0] mem [128];
  logic        mem_init;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hC000_0000 | 32'(i);
    end else if (imem_we) begin
      mem[imem_write_addr] <= imem_write_data;
    end
  end

  assign imem_read_data = mem[imem_read_addr];

  instruction_fetch_unit dut (
    .clk(clk), .rst_all(rst_all), .boot_start(boot_start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .imem_we(imem_we),
    .imem_write_addr(imem_write_addr), .imem_write_data(imem_write_data),
    .imem_read_addr(imem_read_addr), .imem_read_data(imem_read_data),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .halt_req(halt_req), .if_instr(if_instr), .if_pc(if_pc),
    .if_valid(if_valid), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_all = 1'b1;
    load_valid = 1'b1;
    tick();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%h exp=0", if_instr); end
    checks++; if (if_pc !== 7'd0) begin failures++; $display("FAIL reset_if_pc got=%0d exp=0", if_pc); end
    checks++; if (imem_read_addr !== 7'd0) begin failures++; $display("FAIL reset_read_addr got=%0d exp=0", imem_read_addr); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_imem_we got=%b exp=0", imem_we); end
    rst_all = 1'b0;
    load_valid = 1'b0;
    tick();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_hold_state got=%0d exp=0", state); end
    $display("reset done");
  endtask

  task automatic test_boot_load();
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL boot_enter_load got=%0d exp=1", state); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL boot_load_ready got=%b exp=1", load_ready); end
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hA000_0000 + 32'(i);
      load_last  = (i == 3);
      #1;
      checks++; if (imem_we !== 1'b1 || imem_write_addr !== 7'(i) || imem_write_data !== load_data) begin
        failures++; $display("FAIL boot_write we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h", imem_we, imem_write_addr, imem_write_data, i, load_data);
      end
      tick();
      $display("load word addr=%0d data=%h", i, 32'hA000_0000 + 32'(i));
      checks++; if (state !== ((i == 3) ? 2'd2 : 2'd1)) begin failures++; $display("FAIL boot_state_after_word%0d got=%0d", i, state); end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_read_addr !== 7'd0) begin failures++; $display("FAIL run_entry if_valid=%b read_addr=%0d exp 0/0", if_valid, imem_read_addr); end
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("fetch pc=%0d instr=%h valid=%b", if_pc, if_instr, if_valid);
      checks++; if (if_valid !== 1'b1 || if_pc !== 7'(k) || if_instr !== 32'hA000_0000 + 32'(k)) begin
        failures++; $display("FAIL boot_fetch%0d valid=%b pc=%0d instr=%h exp valid=1 pc=%0d instr=%h", k, if_valid, if_pc, if_instr, k, 32'hA000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_load_gaps();
    int pat [6] = '{1, 0, 1, 1, 0, 1};
    logic [31:0] exp_words [4] = '{32'hB000_0000, 32'hB000_0002, 32'hB000_0003, 32'hB000_0005};
    int acc = 0;
    rst_all = 1'b1;
    tick();
    rst_all = 1'b0;
    checks++; if (state !== 2'd0 || if_valid !== 1'b0) begin failures++; $display("FAIL run_reset state=%0d valid=%b exp 0/0", state, if_valid); end
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      load_valid = pat[j][0];
      load_data  = 32'hB000_0000 + 32'(j);
      load_last  = (pat[j] == 1) && (acc == 3);
      #1;
      checks++; if (imem_we !== pat[j][0] || imem_write_addr !== 7'(acc)) begin
        failures++; $display("FAIL gap_cycle%0d we=%b addr=%0d exp we=%0d addr=%0d", j, imem_we, imem_write_addr, pat[j], acc);
      end
      tick();
      if (pat[j] == 1) acc++;
      $display("load cycle=%0d valid=%0d accepted=%0d", j, pat[j], acc);
      checks++; if (state !== ((acc == 4) ? 2'd2 : 2'd1)) begin failures++; $display("FAIL gap_state%0d got=%0d", j, state); end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("fetch pc=%0d instr=%h valid=%b", if_pc, if_instr, if_valid);
      checks++; if (if_valid !== 1'b1 || if_pc !== 7'(k) || if_instr !== exp_words[k]) begin
        failures++; $display("FAIL gap_fetch%0d pc=%0d instr=%h exp pc=%0d instr=%h", k, if_pc, if_instr, k, exp_words[k]);
      end
    end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (if_pc !== 7'd4 || if_instr !== 32'hC000_0004 || imem_read_addr !== 7'd5) begin
      failures++; $display("FAIL stall_setup pc=%0d instr=%h raddr=%0d exp 4/c0000004/5", if_pc, if_instr, imem_read_addr);
    end
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("stall cycle=%0d if_pc=%0d raddr=%0d", c, if_pc, imem_read_addr);
      checks++; if (if_pc !== 7'd4 || if_instr !== 32'hC000_0004 || if_valid !== 1'b1 || imem_read_addr !== 7'd5) begin
        failures++; $display("FAIL stall_hold%0d pc=%0d instr=%h valid=%b raddr=%0d exp 4/c0000004/1/5", c, if_pc, if_instr, if_valid, imem_read_addr);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_pc !== 7'd5 || if_instr !== 32'hC000_0005 || if_valid !== 1'b1 || imem_read_addr !== 7'd6) begin
      failures++; $display("FAIL stall_resume pc=%0d instr=%h raddr=%0d exp 5/c0000005/6", if_pc, if_instr, imem_read_addr);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1;
    redirect_addr = 7'h7F;
    stall = 1'b1;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    $display("redirect to %h", 7'h7F);
    checks++; if (if_valid !== 1'b0 || imem_read_addr !== 7'h7F || if_pc !== 7'd5 || if_instr !== 32'hC000_0005) begin
      failures++; $display("FAIL redirect_flush valid=%b raddr=%h pc=%0d instr=%h exp 0/7f/5/c0000005", if_valid, imem_read_addr, if_pc, if_instr);
    end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 7'h7F || if_instr !== 32'hC000_007F || imem_read_addr !== 7'd0) begin
      failures++; $display("FAIL redirect_target valid=%b pc=%h instr=%h raddr=%0d exp 1/7f/c000007f/0", if_valid, if_pc, if_instr, imem_read_addr);
    end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 7'd0 || if_instr !== 32'hB000_0000 || imem_read_addr !== 7'd1) begin
      failures++; $display("FAIL redirect_wrap valid=%b pc=%0d instr=%h raddr=%0d exp 1/0/b0000000/1", if_valid, if_pc, if_instr, imem_read_addr);
    end
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    redirect = 1'b1;
    redirect_addr = 7'h20;
    tick();
    $display("halt state=%0d", state);
    checks++; if (state !== 2'd3 || imem_read_addr !== 7'd1 || if_valid !== 1'b0 || if_instr !== 32'hB000_0000) begin
      failures++; $display("FAIL halt_enter state=%0d raddr=%0d valid=%b instr=%h exp 3/1/0/b0000000", state, imem_read_addr, if_valid, if_instr);
    end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    halt_req = 1'b0;
    redirect = 1'b0;
    checks++; if (state !== 2'd3 || imem_read_addr !== 7'd1 || if_valid !== 1'b0) begin
      failures++; $display("FAIL halt_ignore state=%0d raddr=%0d valid=%b exp 3/1/0", state, imem_read_addr, if_valid);
    end
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    checks++; if (state !== 2'd1 || imem_write_addr !== 7'd0 || load_ready !== 1'b1 || imem_we !== 1'b0) begin
      failures++; $display("FAIL halt_to_load state=%0d waddr=%0d ready=%b we=%b exp 1/0/1/0", state, imem_write_addr, load_ready, imem_we);
    end
  endtask

  task automatic test_full_stream();
    for (int i = 0; i < 128; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hD000_0000 + 32'(i);
      load_last  = 1'b0;
      #1;
      checks++; if (imem_write_addr !== 7'(i) || imem_we !== 1'b1) begin
        failures++; $display("FAIL full_addr%0d got=%0d we=%b", i, imem_write_addr, imem_we);
      end
      tick();
      $display("load word addr=%0d data=%h", i, 32'hD000_0000 + 32'(i));
      checks++; if (state !== ((i == 127) ? 2'd2 : 2'd1)) begin failures++; $display("FAIL full_state%0d got=%0d", i, state); end
    end
    load_valid = 1'b0;
    checks++; if (imem_read_addr !== 7'd0) begin failures++; $display("FAIL full_run_pc got=%0d exp=0", imem_read_addr); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (if_pc !== 7'(k) || if_instr !== 32'hD000_0000 + 32'(k) || if_valid !== 1'b1) begin
        failures++; $display("FAIL full_fetch%0d pc=%0d instr=%h", k, if_pc, if_instr);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] exp_w;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hE000_0000 + 32'(i);
      tick();
    end
    load_valid = 1'b0;
    rst_all = 1'b1;
    tick();
    rst_all = 1'b0;
    $display("reset mid-load state=%0d", state);
    checks++; if (state !== 2'd0 || load_ready !== 1'b0 || if_valid !== 1'b0 || imem_read_addr !== 7'd0) begin
      failures++; $display("FAIL midload_reset state=%0d ready=%b valid=%b raddr=%0d exp 0/0/0/0", state, load_ready, if_valid, imem_read_addr);
    end
    // One-word boot overwriting address 0, then fetch back the survivors.
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = 32'hF000_0000;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL single_word_run got=%0d exp=2", state); end
    for (int k = 0; k < 11; k++) begin
      tick();
      if (k == 0)      exp_w = 32'hF000_0000;
      else if (k < 10) exp_w = 32'hE000_0000 + 32'(k);
      else             exp_w = 32'hD000_000A;
      $display("fetch pc=%0d instr=%h valid=%b", if_pc, if_instr, if_valid);
      checks++; if (if_pc !== 7'(k) || if_instr !== exp_w || if_valid !== 1'b1) begin
        failures++; $display("FAIL readback%0d pc=%0d instr=%h exp pc=%0d instr=%h", k, if_pc, if_instr, k, exp_w);
      end
    end
  endtask

  initial begin
    rst_all = 1'b1; boot_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    halt_req = 1'b0; mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    test_reset();
    test_boot_load();
    test_load_gaps();
    test_stall();
    test_redirect();
    test_halt();
    test_full_stream();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
